// File: rtl/rf_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_seq_pkg
//  Purpose  : Shared defaults and enumerations for the register-file
//             operation sequencer (op codes and FSM states).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package rf_seq_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  // Command op-code encoding as presented on the command interface
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_LDI = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

endpackage : rf_seq_pkg
`default_nettype wire

// File: rtl/rf_op_sequencer_alu.sv
`default_nettype none
// ============================================================================
//  Module   : rf_seq_alu
//  Purpose  : Combinational datapath for the sequencer.
//             ADD -> a+b, carry = carry-out of the MSB
//             SUB -> a-b, carry = borrow (a < b unsigned)
//             XOR -> a^b, carry = 0
//             LDI -> imm, carry = 0
//  Ports    : i_op      operation select
//             i_a, i_b  operands (register file read data)
//             i_imm     immediate for LDI
//             o_result  computed value, o_carry carry/borrow
//  Revision : 1.0  initial release
// ============================================================================
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  op_e               i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);

  // One extra bit captures the carry-out of ADD and the borrow of SUB
  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      OP_SUB: begin
        o_result = w_diff[DATA_W-1:0];
        o_carry  = w_diff[DATA_W];
      end
      OP_XOR: begin
        o_result = i_a ^ i_b;
        o_carry  = 1'b0;
      end
      default: begin
        o_result = i_imm;
        o_carry  = 1'b0;
      end
    endcase
  end

endmodule : rf_seq_alu
`default_nettype wire

// File: rtl/rf_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rf_op_sequencer
//  Purpose  : Accepts one register-file command at a time, reads the source
//             registers, computes ADD/SUB/XOR (or takes an LDI immediate)
//             and writes the result back through the register file write
//             port. IDLE -> FETCH -> WRITE for ALU ops, IDLE -> WRITE for LDI.
//  Ports    : clk, rst_n                 clock, async active-low reset
//             i_cmd_valid / o_cmd_ready  command handshake
//             i_cmd_op/rd/rs1/rs2/imm    command fields
//             o_rf_read_addr1/2          register file read addresses
//             i_rf_read_port1/2          register file read data (comb.)
//             o_rf_write_addr/data_out/write_en  register file write port
//             o_done, o_result, o_carry  completion report
//  Revision : 1.0  initial release
// ============================================================================
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_rd,
  input  logic [ADDR_W-1:0] i_cmd_rs1,
  input  logic [ADDR_W-1:0] i_cmd_rs2,
  input  logic [DATA_W-1:0] i_cmd_imm,
  output logic [ADDR_W-1:0] o_rf_read_addr1,
  output logic [ADDR_W-1:0] o_rf_read_addr2,
  input  logic [DATA_W-1:0] i_rf_read_port1,
  input  logic [DATA_W-1:0] i_rf_read_port2,
  output logic [ADDR_W-1:0] o_rf_write_addr,
  output logic [DATA_W-1:0] o_rf_data_out,
  output logic              o_rf_write_en,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);

  state_e              r_state;
  op_e                 r_op;
  logic [ADDR_W-1:0]   r_rd;
  logic [ADDR_W-1:0]   r_rs1;
  logic [ADDR_W-1:0]   r_rs2;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_result;
  logic                r_carry;
  logic                r_done;
  logic                r_we;

  op_e                 w_cmd_op;
  op_e                 w_alu_op;
  logic                w_accept;
  logic [DATA_W-1:0]   w_alu_result;
  logic                w_alu_carry;

  assign w_cmd_op = op_e'(i_cmd_op);

  // Gated by rst_n so the block never advertises readiness while held in reset
  assign o_cmd_ready = rst_n && (r_state == ST_IDLE);
  assign w_accept    = i_cmd_valid && o_cmd_ready;

  // In IDLE the ALU serves an incoming LDI straight from the command bus;
  // in FETCH it works on the captured op and the live read data of rs1/rs2.
  assign w_alu_op = (r_state == ST_IDLE) ? w_cmd_op : r_op;

  rf_seq_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_op     (w_alu_op),
    .i_a      (i_rf_read_port1),
    .i_b      (i_rf_read_port2),
    .i_imm    (i_cmd_imm),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry)
  );

  // Operands are consumed at the end of FETCH; registering the ALU output
  // there keeps the write data stable for the whole WRITE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_ADD;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_wr_addr <= '0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_done    <= 1'b0;
      r_we      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op  <= w_cmd_op;
            r_rd  <= i_cmd_rd;
            r_rs1 <= i_cmd_rs1;
            r_rs2 <= i_cmd_rs2;
            if (w_cmd_op == OP_LDI) begin
              r_result  <= w_alu_result;
              r_carry   <= w_alu_carry;
              r_wr_addr <= i_cmd_rd;
              r_we      <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= ST_WRITE;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          r_result  <= w_alu_result;
          r_carry   <= w_alu_carry;
          r_wr_addr <= r_rd;
          r_we      <= 1'b1;
          r_done    <= 1'b1;
          r_state   <= ST_WRITE;
        end
        ST_WRITE: begin
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rf_read_addr1 = r_rs1;
  assign o_rf_read_addr2 = r_rs2;
  assign o_rf_write_addr = r_wr_addr;
  assign o_rf_data_out   = r_result;
  assign o_rf_write_en   = r_we;
  assign o_done          = r_done;
  assign o_result        = r_result;
  assign o_carry         = r_carry;

endmodule : rf_op_sequencer
`default_nettype wire

// File: tb/tb_rf_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_op_sequencer
//  Purpose  : Self-checking bench for rf_op_sequencer with an attached
//             16x16 register file and a reference register image.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [15:0] cmd_imm;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [15:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_we;
  logic        done;
  logic [15:0] result;
  logic        carry;

  logic        rf_clr;
  logic [15:0] rf_mem [16];

  int          ref_rf [16];
  int          n_total;
  int          n_bad;
  logic [15:0] last_res;
  logic        last_c;
  int          last_wait;

  rf_op_sequencer #(
    .DATA_W (16),
    .ADDR_W (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_cmd_valid     (cmd_valid),
    .o_cmd_ready     (cmd_ready),
    .i_cmd_op        (cmd_op),
    .i_cmd_rd        (cmd_rd),
    .i_cmd_rs1       (cmd_rs1),
    .i_cmd_rs2       (cmd_rs2),
    .i_cmd_imm       (cmd_imm),
    .o_rf_read_addr1 (rf_raddr1),
    .o_rf_read_addr2 (rf_raddr2),
    .i_rf_read_port1 (rf_rdata1),
    .i_rf_read_port2 (rf_rdata2),
    .o_rf_write_addr (rf_waddr),
    .o_rf_data_out   (rf_wdata),
    .o_rf_write_en   (rf_we),
    .o_done          (done),
    .o_result        (result),
    .o_carry         (carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file: combinational read, synchronous write, separate clear
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, result} from plain integer arithmetic
  function automatic logic [16:0] model(input int op, input int a, input int b, input int imm);
    int r;
    int c;
    case (op)
      0: begin r = a + b; c = (r > 65535) ? 1 : 0; r = r % 65536; end
      1: begin c = (a < b) ? 1 : 0; r = (a - b + 65536) % 65536; end
      2: begin r = a ^ b; c = 0; end
      default: begin r = imm; c = 0; end
    endcase
    return {c[0], r[15:0]};
  endfunction

  // Starts at a falling edge, ends at the falling edge inside WRITE
  task automatic do_cmd(input int op, input int rd, input int rs1, input int rs2, input int imm);
    int waitc;
    int lat;
    int exp_lat;
    logic [16:0] m;
    cmd_op    = op[1:0];
    cmd_rd    = rd[3:0];
    cmd_rs1   = rs1[3:0];
    cmd_rs2   = rs2[3:0];
    cmd_imm   = imm[15:0];
    cmd_valid = 1'b1;
    waitc = 0;
    while (cmd_ready !== 1'b1 && waitc < 8) begin
      @(negedge clk);
      waitc++;
    end
    last_wait = waitc;
    if (cmd_ready !== 1'b1) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    m = model(op, ref_rf[rs1], ref_rf[rs2], imm);
    exp_lat = (op == 3) ? 1 : 2;
    @(posedge clk);
    @(negedge clk);
    // Scramble the bus: the DUT must rely on its captured fields
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_rd    = 4'($urandom);
    cmd_rs1   = 4'($urandom);
    cmd_rs2   = 4'($urandom);
    cmd_imm   = 16'($urandom);
    lat = 1;
    while (rf_we !== 1'b1 && lat < 4) begin
      chk("fetch_ready", cmd_ready, 0);
      chk("fetch_done", done, 0);
      chk("fetch_raddr1", rf_raddr1, rs1);
      chk("fetch_raddr2", rf_raddr2, rs2);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("wr_ready", cmd_ready, 0);
    chk("wr_en", rf_we, 1);
    chk("wr_addr", rf_waddr, rd);
    chk("wr_data", rf_wdata, m[15:0]);
    chk("wr_done", done, 1);
    chk("wr_result", result, m[15:0]);
    chk("wr_carry", carry, m[16]);
    ref_rf[rd] = int'(m[15:0]);
    last_res   = m[15:0];
    last_c     = m[16];
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_we", rf_we, 0);
    chk("idle_done", done, 0);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_result", result, last_res);
    chk("idle_carry", carry, last_c);
  endtask

  task automatic check_rf();
    for (int i = 0; i < 16; i++)
      chk($sformatf("rf_r%0d", i), rf_mem[i], ref_rf[i]);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    last_res  = '0;
    last_c    = 1'b0;
    last_wait = 0;
    for (int i = 0; i < 16; i++) ref_rf[i] = 0;
    rst_n     = 1'b0;
    rf_clr    = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_rd    = '0;
    cmd_rs1   = '0;
    cmd_rs2   = '0;
    cmd_imm   = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_raddr1", rf_raddr1, 0);
    chk("rst_raddr2", rf_raddr2, 0);
    chk("rst_waddr", rf_waddr, 0);
    rst_n  = 1'b1;
    rf_clr = 1'b0;
    #1;
    chk("ready_after_release", cmd_ready, 1);
    @(negedge clk);

    // LDI r3 = 0x1234
    do_cmd(3, 3, 0, 0, 'h1234);
    idle_check();
    chk("ldi_r3", rf_mem[3], 16'h1234);

    // ADD overflow: 0xFFFF + 0x0001
    do_cmd(3, 1, 0, 0, 'hFFFF);
    do_cmd(3, 2, 0, 0, 'h0001);
    do_cmd(0, 4, 1, 2, 0);
    idle_check();
    chk("add_r4", rf_mem[4], 16'h0000);
    chk("add_carry", carry, 1);

    // SUB both directions, then rs1 == rs2
    do_cmd(3, 1, 0, 0, 'h0005);
    do_cmd(3, 2, 0, 0, 'h0007);
    do_cmd(1, 5, 1, 2, 0);
    idle_check();
    chk("sub_r5", rf_mem[5], 16'hFFFE);
    chk("sub_borrow", carry, 1);
    do_cmd(1, 6, 2, 1, 0);
    idle_check();
    chk("sub_r6", rf_mem[6], 16'h0002);
    chk("sub_noborrow", carry, 0);
    do_cmd(1, 9, 5, 5, 0);
    idle_check();
    chk("sub_same", rf_mem[9], 16'h0000);

    // LDI then XOR issued immediately: one stall cycle, sees prior write
    do_cmd(3, 7, 0, 0, 'h00F0);
    do_cmd(2, 7, 7, 7, 0);
    chk("xor_stall", last_wait, 1);
    idle_check();
    chk("xor_r7", rf_mem[7], 16'h0000);

    // Reset during FETCH of ADD r8 = r1 + r2
    do_cmd(3, 1, 0, 0, 'hFFFF);
    do_cmd(3, 2, 0, 0, 'h0001);
    do_cmd(3, 8, 0, 0, 'hABCD);
    idle_check();
    cmd_op = 2'd0; cmd_rd = 4'd8; cmd_rs1 = 4'd1; cmd_rs2 = 4'd2; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_fetch_ready", cmd_ready, 0);
    chk("abort_fetch_raddr1", rf_raddr1, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_we", rf_we, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_carry", carry, 0);
    chk("abort_raddr1", rf_raddr1, 0);
    chk("abort_waddr", rf_waddr, 0);
    chk("abort_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_ready_release", cmd_ready, 1);
    last_res = '0;
    last_c   = 1'b0;
    idle_check();
    chk("abort_r8", rf_mem[8], 16'hABCD);

    // Randomized traffic against the reference register image
    for (int n = 0; n < 80; n++) begin
      do_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 65535)));
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();
    check_rf();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_rf_op_sequencer
`default_nettype wire
